// File: rtl/uart_fifo_bridge.sv
// Byte FIFOs between the UART CSR fields and the uart core's AXI-Stream ports:
// a CSR-filled TX FIFO draining to the core, and a core-filled RX FIFO drained by CSR reads.
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  tx_wr_i,
    input  logic [7:0]            tx_data_i,
    output logic                  tx_full_o,
    output logic                  tx_busy_o,
    output logic [DEPTH_LOG2:0]   tx_level_o,
    input  logic                  uart_tx_busy_i,
    output logic [7:0]            m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    input  logic [7:0]            s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic                  rx_rd_i,
    output logic [7:0]            rx_data_o,
    output logic                  rx_not_empty_o,
    output logic [DEPTH_LOG2:0]   rx_level_o,
    input  logic                  ovf_clr_i,
    output logic                  tx_ovf_o,
    output logic                  rx_ovf_o
);

    localparam int                   DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]  CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [7:0]            tx_mem_q [DEPTH];
    logic [7:0]            rx_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic                  tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic                  rdy_q, rdy_d;

    logic tx_full, tx_empty, tx_push, tx_pop, tx_drop;
    logic rx_full, rx_empty, rx_accept, rx_push, rx_pop, rx_drop;

    // Both streams use AXI-Stream valid/ready: a byte moves on a rising edge only when
    // valid and ready are both high; valid never waits for ready, and data is stable while valid.
    // Full/empty come from the registered count, so a pop never frees room for a same-cycle push.
    always_comb begin
        tx_full   = (tx_cnt_q == FULL_CNT);
        tx_empty  = (tx_cnt_q == '0);
        tx_push   = tx_wr_i && !tx_full;
        tx_drop   = tx_wr_i && tx_full;
        tx_pop    = !tx_empty && m_axis_tready_i;

        rx_full   = (rx_cnt_q == FULL_CNT);
        rx_empty  = (rx_cnt_q == '0);
        rx_accept = s_axis_tvalid_i && rdy_q;
        rx_push   = rx_accept && !rx_full;
        rx_drop   = rx_accept && rx_full;
        rx_pop    = rx_rd_i && !rx_empty;

        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + PTR_ONE : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + PTR_ONE : tx_rd_ptr_q;
        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + PTR_ONE : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + PTR_ONE : rx_rd_ptr_q;

        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;

        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
        else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;

        // A drop in the same cycle as a clear keeps the flag set.
        tx_ovf_d = tx_drop || (tx_ovf_q && !ovf_clr_i);
        rx_ovf_d = rx_drop || (rx_ovf_q && !ovf_clr_i);
        rdy_d    = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            tx_ovf_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_ovf_q    <= rx_ovf_d;
            rdy_q       <= rdy_d;
        end
    end

    // Storage is deliberately left unreset; contents behind an empty FIFO are don't-care.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= tx_data_i;
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= s_axis_tdata_i;
    end

    assign tx_full_o       = tx_full;
    assign tx_level_o      = tx_cnt_q;
    assign tx_busy_o       = (tx_cnt_q != '0) || uart_tx_busy_i;
    assign m_axis_tdata_o  = tx_mem_q[tx_rd_ptr_q];
    assign m_axis_tvalid_o = !tx_empty;
    assign s_axis_tready_o = rdy_q;
    assign rx_data_o       = rx_mem_q[rx_rd_ptr_q];
    assign rx_not_empty_o  = !rx_empty;
    assign rx_level_o      = rx_cnt_q;
    assign tx_ovf_o        = tx_ovf_q;
    assign rx_ovf_o        = rx_ovf_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: TX ordering/overflow, RX overflow and empty reads,
// clear-vs-set priority and asynchronous mid-operation reset.
module tb_uart_fifo_bridge;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       tx_wr_i;
    logic [7:0] tx_data_i;
    logic       tx_full_o, tx_busy_o;
    logic [4:0] tx_level_o;
    logic       uart_tx_busy_i;
    logic [7:0] m_axis_tdata_o;
    logic       m_axis_tvalid_o, m_axis_tready_i;
    logic [7:0] s_axis_tdata_i;
    logic       s_axis_tvalid_i, s_axis_tready_o;
    logic       rx_rd_i;
    logic [7:0] rx_data_o;
    logic       rx_not_empty_o;
    logic [4:0] rx_level_o;
    logic       ovf_clr_i, tx_ovf_o, rx_ovf_o;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic       rdy_ok;

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .tx_wr_i(tx_wr_i), .tx_data_i(tx_data_i), .tx_full_o(tx_full_o),
        .tx_busy_o(tx_busy_o), .tx_level_o(tx_level_o), .uart_tx_busy_i(uart_tx_busy_i),
        .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tvalid_o(m_axis_tvalid_o),
        .m_axis_tready_i(m_axis_tready_i),
        .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tvalid_i(s_axis_tvalid_i),
        .s_axis_tready_o(s_axis_tready_o),
        .rx_rd_i(rx_rd_i), .rx_data_o(rx_data_o), .rx_not_empty_o(rx_not_empty_o),
        .rx_level_o(rx_level_o), .ovf_clr_i(ovf_clr_i),
        .tx_ovf_o(tx_ovf_o), .rx_ovf_o(rx_ovf_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] b);
        tx_wr_i   = 1'b1;
        tx_data_i = b;
        tick();
        tx_wr_i   = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        s_axis_tvalid_i = 1'b1;
        s_axis_tdata_i  = b;
        tick();
        s_axis_tvalid_i = 1'b0;
    endtask

    task automatic rx_read();
        rx_rd_i = 1'b1;
        tick();
        rx_rd_i = 1'b0;
    endtask

    task automatic tx_drain_check(input string tag, input int n);
        m_axis_tready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, m_axis_tvalid_o, 1'b1);
            check({tag, "_data"}, m_axis_tdata_o, exp_q.pop_front());
            tick();
        end
        m_axis_tready_i = 1'b0;
    endtask

    task automatic clear_ovf();
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
    endtask

    initial begin
        rst_n_i = 1'b0; tx_wr_i = 1'b0; tx_data_i = '0; uart_tx_busy_i = 1'b1;
        m_axis_tready_i = 1'b0; s_axis_tdata_i = '0; s_axis_tvalid_i = 1'b0;
        rx_rd_i = 1'b0; ovf_clr_i = 1'b0;
        #12;
        check("rst_busy_follows_uart", tx_busy_o, 1'b1);
        uart_tx_busy_i = 1'b0;
        #1;
        check("rst_busy", tx_busy_o, 1'b0);
        check("rst_full", tx_full_o, 1'b0);
        check("rst_tvalid", m_axis_tvalid_o, 1'b0);
        check("rst_rx_ne", rx_not_empty_o, 1'b0);
        check("rst_ovf", {tx_ovf_o, rx_ovf_o}, 2'b00);
        check("rst_tready", s_axis_tready_o, 1'b0);
        @(negedge clk_i) rst_n_i = 1'b1;
        tick(); tick();
        check("tready_after_rst", s_axis_tready_o, 1'b1);

        // 1: three bytes queued, then drained in order
        foreach (exp_q[i]) ;
        tx_write(8'h41); tx_write(8'h42); tx_write(8'h43);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        check("t1_level", tx_level_o, 5'd3);
        check("t1_head", m_axis_tdata_o, 8'h41);
        check("t1_busy", tx_busy_o, 1'b1);
        tx_drain_check("t1_drain", 3);
        check("t1_tvalid_end", m_axis_tvalid_o, 1'b0);
        check("t1_level_end", tx_level_o, 5'd0);
        check("t1_busy_end", tx_busy_o, 1'b0);

        // 2: 17 writes into a 16-deep FIFO
        for (int i = 0; i < 16; i++) begin
            tx_write(8'(i));
            exp_q.push_back(8'(i));
        end
        check("t2_full", tx_full_o, 1'b1);
        check("t2_ovf_before", tx_ovf_o, 1'b0);
        tx_write(8'h10);
        check("t2_ovf", tx_ovf_o, 1'b1);
        check("t2_level", tx_level_o, 5'd16);
        tx_drain_check("t2_drain", 16);
        check("t2_empty", m_axis_tvalid_o, 1'b0);
        clear_ovf();
        check("t2_ovf_clr", tx_ovf_o, 1'b0);

        // 3: write into a full FIFO while it pops: pop happens, write dropped
        for (int i = 0; i < 16; i++) begin
            tx_write(8'(8'h20 + i));
            exp_q.push_back(8'(8'h20 + i));
        end
        tx_wr_i = 1'b1; tx_data_i = 8'h55; m_axis_tready_i = 1'b1;
        tick();
        tx_wr_i = 1'b0; m_axis_tready_i = 1'b0;
        void'(exp_q.pop_front());
        check("t3_level", tx_level_o, 5'd15);
        check("t3_ovf", tx_ovf_o, 1'b1);
        tx_drain_check("t3_drain", 15);
        check("t3_empty", tx_level_o, 5'd0);
        clear_ovf();

        // 4: 20 RX bytes with no reads
        rdy_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx_push(8'(8'h80 + i));
            rdy_ok &= s_axis_tready_o;
        end
        check("t4_tready_held", rdy_ok, 1'b1);
        check("t4_level", rx_level_o, 5'd16);
        check("t4_ovf", rx_ovf_o, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check("t4_rd_data", rx_data_o, 8'(8'h80 + i));
            rx_read();
        end
        check("t4_ne_end", rx_not_empty_o, 1'b0);
        rx_read();
        check("t4_extra_level", rx_level_o, 5'd0);
        check("t4_extra_ne", rx_not_empty_o, 1'b0);
        check("t4_extra_ovf", rx_ovf_o, 1'b1);

        // 5: clear coinciding with a new drop keeps the flag
        for (int i = 0; i < 16; i++) rx_push(8'(8'hA0 + i));
        s_axis_tvalid_i = 1'b1; s_axis_tdata_i = 8'hEE; ovf_clr_i = 1'b1;
        tick();
        s_axis_tvalid_i = 1'b0; ovf_clr_i = 1'b0;
        check("t5_set_wins", rx_ovf_o, 1'b1);
        check("t5_level", rx_level_o, 5'd16);
        check("t5_head", rx_data_o, 8'hA0);
        clear_ovf();
        check("t5_clr", rx_ovf_o, 1'b0);

        // 6: asynchronous reset with both FIFOs at level 5
        for (int i = 0; i < 11; i++) rx_read();
        for (int i = 0; i < 5; i++) tx_write(8'(8'h60 + i));
        check("t6_rx_level", rx_level_o, 5'd5);
        check("t6_tx_level", tx_level_o, 5'd5);
        #2 rst_n_i = 1'b0;
        #1;
        check("t6_tx_level_rst", tx_level_o, 5'd0);
        check("t6_rx_level_rst", rx_level_o, 5'd0);
        check("t6_tvalid_rst", m_axis_tvalid_o, 1'b0);
        check("t6_ne_rst", rx_not_empty_o, 1'b0);
        check("t6_busy_rst", tx_busy_o, 1'b0);
        check("t6_tready_rst", s_axis_tready_o, 1'b0);
        @(negedge clk_i) rst_n_i = 1'b1;
        tick(); tick();
        check("t6_levels_after", {tx_level_o, rx_level_o}, 10'd0);
        check("t6_tready_after", s_axis_tready_o, 1'b1);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
